// File: rtl/mem_initiator_if.sv
// mem_initiator_if: core-side burst handshake plus memory port bundle for mem_initiator.
interface mem_initiator_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] wdata;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;
  logic              done;
  logic              err;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_rdata,
    output req_ready, wdata_ready, rdata, rdata_valid, done, err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_rdata,
    input  req_ready, wdata_ready, rdata, rdata_valid, done, err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_initiator.sv
// mem_initiator: load/store burst sequencer for a 32x8 synchronous memory.
// Define MEM_INIT_BOUND_CHK_EN to reject bursts running past the top address instead of wrapping.
module mem_initiator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_initiator_if.slave m
);
  typedef enum logic [1:0] {IDLE, RD, RD_DRAIN, WR} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_rvalid, r_done;
  logic              w_accept, w_bad, w_last, w_step;
  assign w_accept = m.req_valid && r_state == IDLE;
  assign w_last   = r_cnt == '0;
  assign w_step   = m.mem_rd || m.mem_wr;
`ifdef MEM_INIT_BOUND_CHK_EN
  logic r_err;
  assign w_bad = (ADDR_W+1)'(m.req_addr) + (ADDR_W+1)'(m.req_len) > (ADDR_W+1)'(2**ADDR_W - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && w_bad;
  end
  assign m.err = r_err;
`else
  assign w_bad = 1'b0;
  assign m.err = 1'b0;
`endif
  assign m.req_ready   = r_state == IDLE;
  assign m.wdata_ready = r_state == WR;
  assign m.mem_rd      = r_state == RD;
  assign m.mem_wr      = r_state == WR && m.wdata_valid;
  assign m.mem_addr    = r_addr;
  assign m.mem_wdata   = r_state == WR ? m.wdata : {DATA_W{1'b0}};
  assign m.rdata       = m.mem_rdata;
  assign m.rdata_valid = r_rvalid;
  assign m.done        = r_done;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_accept && !w_bad) w_next = m.req_write ? WR : RD;
      RD:       if (w_last) w_next = RD_DRAIN;
      RD_DRAIN: w_next = IDLE;
      WR:       if (m.wdata_valid && w_last) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // done is registered off the final strobe so loads align it with the last rdata_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rvalid <= m.mem_rd;
      r_done   <= w_step && w_last;
      if (w_accept) begin
        r_addr <= m.req_addr;
        r_cnt  <= m.req_len;
      end else if (w_step) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_cnt  <= r_cnt - LEN_W'(1);
      end
    end
  end
endmodule
